// File: rtl/tag_channel_filter.sv
`timescale 1ns/1ps
// Tag channel filter: per-channel enable mask and dead-time suppression.
// Rejected tags only lose their tkeep lane. Every beat is forwarded with its
// tag times, channels and lowest_time_bound unchanged.
// Datapath: one output register backed by a 1-entry skid buffer.
module tag_channel_filter #(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6,
  parameter int NUM_CHANNELS  = 32,
  parameter int DEAD_WIDTH    = 24
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [WORD_WIDTH-1:0]               s_axis_tkeep,
  input  logic [WORD_WIDTH*TIME_WIDTH-1:0]    s_axis_tagtime,
  input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] s_axis_channel,
  input  logic [TIME_WIDTH-1:0]               s_axis_lowest_time_bound,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [WORD_WIDTH-1:0]               m_axis_tkeep,
  output logic [WORD_WIDTH*TIME_WIDTH-1:0]    m_axis_tagtime,
  output logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] m_axis_channel,
  output logic [TIME_WIDTH-1:0]               m_axis_lowest_time_bound,
  input  logic [NUM_CHANNELS-1:0]             cfg_mask,
  input  logic [DEAD_WIDTH-1:0]               cfg_dead,
  input  logic                                cfg_load,
  output logic [31:0]                         dropped_count
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0] act_mask;
  logic [DEAD_WIDTH-1:0]   act_dead;
  logic [TIME_WIDTH-1:0]   dead_ext;
  logic [TIME_WIDTH-1:0]   last_q [NUM_CHANNELS];
  logic [TIME_WIDTH-1:0]   last_n [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] hist_v_q;
  logic [NUM_CHANNELS-1:0] hist_v_n;

  logic [WORD_WIDTH-1:0]    kept;
  logic [31:0]              drop_n;
  logic [32:0]              cnt_sum;
  logic [CHANNEL_WIDTH-1:0] lane_ch;
  logic [TIME_WIDTH-1:0]    lane_t;
  logic [IDX_W-1:0]         lane_idx;
  logic                     lane_in_range;
  logic                     lane_time_ok;

  logic                                skid_full;
  logic [WORD_WIDTH-1:0]               skid_tkeep;
  logic [WORD_WIDTH*TIME_WIDTH-1:0]    skid_tagtime;
  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] skid_channel;
  logic [TIME_WIDTH-1:0]               skid_ltb;

  logic accept;
  logic out_ready;

  assign s_axis_tready = ~skid_full;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign out_ready     = ~m_axis_tvalid | m_axis_tready;
  assign dead_ext      = TIME_WIDTH'(act_dead);
  assign cnt_sum       = {1'b0, dropped_count} + {1'b0, drop_n};

  // Lane-by-lane filter; later lanes see history updated by earlier kept lanes.
  always_comb begin
    last_n        = last_q;
    hist_v_n      = hist_v_q;
    kept          = '0;
    drop_n        = '0;
    lane_ch       = '0;
    lane_t        = '0;
    lane_idx      = '0;
    lane_in_range = 1'b0;
    lane_time_ok  = 1'b0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      lane_ch       = s_axis_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      lane_t        = s_axis_tagtime[i*TIME_WIDTH +: TIME_WIDTH];
      lane_idx      = lane_ch[IDX_W-1:0];
      lane_in_range = int'(lane_ch) < NUM_CHANNELS;
      // Modular subtraction makes the check immune to tagtime wrap-around.
      lane_time_ok  = (act_dead == '0) | ~hist_v_n[lane_idx] |
                      ((lane_t - last_n[lane_idx]) >= dead_ext);
      kept[i]       = s_axis_tkeep[i] & lane_in_range & act_mask[lane_idx] & lane_time_ok;
      if (kept[i]) begin
        last_n[lane_idx]   = lane_t;
        hist_v_n[lane_idx] = 1'b1;
      end
      drop_n = drop_n + 32'(s_axis_tkeep[i] & ~kept[i]);
    end
  end

  // Active configuration, per-channel history and drop counter.
  // A cfg_load wins over a beat accepted in the same cycle: history and count restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_mask      <= '0;
      act_dead      <= '0;
      hist_v_q      <= '0;
      dropped_count <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) last_q[c] <= '0;
    end else if (cfg_load) begin
      act_mask      <= cfg_mask;
      act_dead      <= cfg_dead;
      hist_v_q      <= '0;
      dropped_count <= '0;
    end else if (accept) begin
      last_q        <= last_n;
      hist_v_q      <= hist_v_n;
      dropped_count <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end

  // Output register with skid buffer; the skid entry always drains first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid            <= 1'b0;
      m_axis_tkeep             <= '0;
      m_axis_tagtime           <= '0;
      m_axis_channel           <= '0;
      m_axis_lowest_time_bound <= '0;
      skid_full                <= 1'b0;
      skid_tkeep               <= '0;
      skid_tagtime             <= '0;
      skid_channel             <= '0;
      skid_ltb                 <= '0;
    end else if (out_ready) begin
      if (skid_full) begin
        m_axis_tvalid            <= 1'b1;
        m_axis_tkeep             <= skid_tkeep;
        m_axis_tagtime           <= skid_tagtime;
        m_axis_channel           <= skid_channel;
        m_axis_lowest_time_bound <= skid_ltb;
        skid_full                <= 1'b0;
      end else if (accept) begin
        m_axis_tvalid            <= 1'b1;
        m_axis_tkeep             <= kept;
        m_axis_tagtime           <= s_axis_tagtime;
        m_axis_channel           <= s_axis_channel;
        m_axis_lowest_time_bound <= s_axis_lowest_time_bound;
      end else begin
        m_axis_tvalid            <= 1'b0;
      end
    end else if (accept) begin
      skid_full    <= 1'b1;
      skid_tkeep   <= kept;
      skid_tagtime <= s_axis_tagtime;
      skid_channel <= s_axis_channel;
      skid_ltb     <= s_axis_lowest_time_bound;
    end
  end

endmodule

// File: tb/tb_tag_channel_filter.sv
`timescale 1ns/1ps
// Directed bench for tag_channel_filter with an output scoreboard.
module tb_tag_channel_filter;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [3:0]   s_axis_tkeep;
  logic [255:0] s_axis_tagtime;
  logic [23:0]  s_axis_channel;
  logic [63:0]  s_axis_lowest_time_bound;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [3:0]   m_axis_tkeep;
  logic [255:0] m_axis_tagtime;
  logic [23:0]  m_axis_channel;
  logic [63:0]  m_axis_lowest_time_bound;
  logic [31:0]  cfg_mask;
  logic [23:0]  cfg_dead;
  logic         cfg_load;
  logic [31:0]  dropped_count;

  typedef struct packed {
    logic [3:0]   keep;
    logic [255:0] tt;
    logic [23:0]  ch;
    logic [63:0]  ltb;
  } beat_t;

  beat_t       sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] ltb_ctr = 64'h100;
  logic [63:0] t_top;

  always #5 clk = ~clk;

  tag_channel_filter dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_axis_tvalid            (s_axis_tvalid),
    .s_axis_tready            (s_axis_tready),
    .s_axis_tkeep             (s_axis_tkeep),
    .s_axis_tagtime           (s_axis_tagtime),
    .s_axis_channel           (s_axis_channel),
    .s_axis_lowest_time_bound (s_axis_lowest_time_bound),
    .m_axis_tvalid            (m_axis_tvalid),
    .m_axis_tready            (m_axis_tready),
    .m_axis_tkeep             (m_axis_tkeep),
    .m_axis_tagtime           (m_axis_tagtime),
    .m_axis_channel           (m_axis_channel),
    .m_axis_lowest_time_bound (m_axis_lowest_time_bound),
    .cfg_mask                 (cfg_mask),
    .cfg_dead                 (cfg_dead),
    .cfg_load                 (cfg_load),
    .dropped_count            (dropped_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t obs, input beat_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat was accepted.
  task automatic send(input logic [3:0] keep,
                      input logic [5:0] c0, input logic [5:0] c1,
                      input logic [5:0] c2, input logic [5:0] c3,
                      input logic [63:0] t0, input logic [63:0] t1,
                      input logic [63:0] t2, input logic [63:0] t3,
                      input logic [3:0] exp_keep);
    int waitc = 0;
    s_axis_tvalid            = 1'b1;
    s_axis_tkeep             = keep;
    s_axis_tagtime           = {t3, t2, t1, t0};
    s_axis_channel           = {c3, c2, c1, c0};
    s_axis_lowest_time_bound = ltb_ctr;
    @(negedge clk);
    while (!s_axis_tready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_timeout", 64'(s_axis_tready), 64'd1);
    if (s_axis_tready) sb.push_back('{exp_keep, {t3, t2, t1, t0}, {c3, c2, c1, c0}, ltb_ctr});
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    ltb_ctr++;
  endtask

  task automatic load_cfg(input logic [31:0] mask, input logic [23:0] dead);
    cfg_mask = mask;
    cfg_dead = dead;
    cfg_load = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tkeep = '0;
    s_axis_tagtime = '0;
    s_axis_channel = '0;
    s_axis_lowest_time_bound = '0;
    m_axis_tready = 1'b1;
    cfg_mask = '0;
    cfg_dead = '0;
    cfg_load = 1'b0;

    // Scoreboard consumer plus hold-stable check while stalled.
    fork
      begin
        beat_t held;
        beat_t cur;
        logic  stalled = 1'b0;
        forever begin
          @(negedge clk);
          if (rst) begin
            stalled = 1'b0;
          end else begin
            cur = '{m_axis_tkeep, m_axis_tagtime, m_axis_channel, m_axis_lowest_time_bound};
            if (stalled) begin
              chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
              chk_beat("hold_stable", cur, held);
            end
            if (m_axis_tvalid && m_axis_tready) begin
              if (sb.size() == 0) chk("unexpected_beat", 64'(sb.size()), 64'd1);
              else chk_beat("sb_beat", cur, sb.pop_front());
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held = cur;
          end
        end
      end
    join_none

    // Reset state
    idle(2);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("rst_m_tagtime", m_axis_tagtime[63:0], 64'd0);
    chk("rst_m_ltb", m_axis_lowest_time_bound, 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_count", 64'(dropped_count), 64'd0);
    rst = 1'b0;
    idle(1);

    // No configuration yet: everything dropped, beats still forwarded
    send(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 64'd10, 64'd20, 64'd30, 64'd40, 4'b0000);
    send(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 64'd11, 64'd21, 64'd31, 64'd41, 4'b0000);
    send(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 64'd12, 64'd22, 64'd32, 64'd42, 4'b0000);
    idle(3);
    chk("nocfg_count", 64'(dropped_count), 64'd12);

    // All enabled, no dead time
    load_cfg(32'hFFFF_FFFF, 24'd0);
    chk("cfg_clears_count", 64'(dropped_count), 64'd0);
    send(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 64'd100, 64'd200, 64'd300, 64'd400, 4'b1111);
    chk("latency_valid", 64'(m_axis_tvalid), 64'd1);
    chk("latency_tkeep", 64'(m_axis_tkeep), 64'hF);
    chk("pass_count", 64'(dropped_count), 64'd0);
    // Out-of-range channels and boundary indices 0/31
    send(4'b1111, 6'd32, 6'd63, 6'd0, 6'd31, 64'd500, 64'd501, 64'd502, 64'd503, 4'b1100);
    chk("range_count", 64'(dropped_count), 64'd2);
    send(4'b0101, 6'd1, 6'd2, 6'd3, 6'd4, 64'd600, 64'd601, 64'd602, 64'd603, 4'b0101);
    send(4'b0000, 6'd1, 6'd2, 6'd3, 6'd4, 64'd700, 64'd701, 64'd702, 64'd703, 4'b0000);
    chk("partial_count", 64'(dropped_count), 64'd2);

    // Dead time 1000 on one channel inside a beat
    load_cfg(32'hFFFF_FFFF, 24'd1000);
    send(4'b1111, 6'd5, 6'd5, 6'd5, 6'd5, 64'd0, 64'd500, 64'd1000, 64'd1999, 4'b0101);
    chk("dead_count", 64'(dropped_count), 64'd2);

    // Wrap-around of tagtime
    load_cfg(32'hFFFF_FFFF, 24'd200);
    t_top = 64'd0 - 64'd100;
    send(4'b1111, 6'd7, 6'd7, 6'd7, 6'd7, t_top, t_top + 64'd50, 64'd150, 64'd349, 4'b0101);
    chk("wrap_count", 64'(dropped_count), 64'd2);

    // Backpressure: 5 stalled cycles with continuous input
    load_cfg(32'hFFFF_FFFF, 24'd0);
    idle(2);
    m_axis_tready = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join_none
    send(4'b1111, 6'd10, 6'd11, 6'd12, 6'd13, 64'd1, 64'd2, 64'd3, 64'd4, 4'b1111);
    send(4'b1111, 6'd14, 6'd15, 6'd16, 6'd17, 64'd5, 64'd6, 64'd7, 64'd8, 4'b1111);
    chk("bp_tready_low", 64'(s_axis_tready), 64'd0);
    for (int b = 0; b < 4; b++)
      send(4'b1111, 6'(20 + b), 6'(24 + b), 6'd0, 6'd1,
           64'(1000 + b), 64'(2000 + b), 64'(3000 + b), 64'(4000 + b), 4'b1111);
    idle(6);
    chk("bp_drained", 64'(sb.size()), 64'd0);
    chk("bp_count", 64'(dropped_count), 64'd0);

    // cfg_load mid-stream: same-cycle beat uses old config, drops discarded
    load_cfg(32'hFFFF_FFFF, 24'd1000);
    send(4'b0001, 6'd5, 6'd0, 6'd0, 6'd0, 64'd10000, 64'd0, 64'd0, 64'd0, 4'b0001);
    cfg_mask = 32'hFFFF_FFF7;
    cfg_dead = 24'd1000;
    cfg_load = 1'b1;
    send(4'b1111, 6'd3, 6'd5, 6'd9, 6'd9, 64'd10100, 64'd10200, 64'd0, 64'd50, 4'b0101);
    cfg_load = 1'b0;
    chk("cfg_same_cycle_count", 64'(dropped_count), 64'd0);
    send(4'b1111, 6'd3, 6'd5, 6'd5, 6'd3, 64'd20000, 64'd10300, 64'd10400, 64'd20001, 4'b0010);
    chk("cfg_new_count", 64'(dropped_count), 64'd3);
    idle(3);
    chk("cfg_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset with beats in flight
    m_axis_tready = 1'b0;
    send(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 64'd1, 64'd2, 64'd3, 64'd4, 4'b1111);
    send(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 64'd5, 64'd6, 64'd7, 64'd8, 4'b1111);
    chk("pre_rst_tready", 64'(s_axis_tready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("async_rst_tready", 64'(s_axis_tready), 64'd1);
    chk("async_rst_count", 64'(dropped_count), 64'd0);
    sb.delete();
    m_axis_tready = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    send(4'b1011, 6'd1, 6'd2, 6'd3, 6'd4, 64'd9, 64'd9, 64'd9, 64'd9, 4'b0000);
    chk("post_rst_count", 64'(dropped_count), 64'd3);
    idle(3);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
